alu_stream_engine: RTL and testbench

//  Synthesizable request/response front-end for ALU operations: the responder end of the

---
 rtl/alu_stream_if.sv | 37 +++
 rtl/alu_stream_engine.sv | 136 +++++++++++++
 tb/tb_alu_stream_engine.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_stream_if.sv
// alu_stream_if: request/response bus between an ALU stimulus source and
// the ALU stream engine.
//   req_valid/req_ready  request handshake, carries req_a, req_b, req_select
//   rsp_valid/rsp_ready  response handshake, carries rsp_out and its flags
//                        (zero, carry, sign, parity, overflow)
// master: the requester that also consumes responses.
// slave : the engine that accepts requests and produces responses.
interface alu_stream_if #(
    parameter int WIDTH = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [WIDTH-1:0] req_a;
    logic [WIDTH-1:0] req_b;
    logic [2:0]       req_select;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_out;
    logic             rsp_zero;
    logic             rsp_carry;
    logic             rsp_sign;
    logic             rsp_parity;
    logic             rsp_overflow;

    modport master (
        output req_valid, req_a, req_b, req_select, rsp_ready,
        input  req_ready, rsp_valid, rsp_out, rsp_zero, rsp_carry,
               rsp_sign, rsp_parity, rsp_overflow
    );

    modport slave (
        input  req_valid, req_a, req_b, req_select, rsp_ready,
        output req_ready, rsp_valid, rsp_out, rsp_zero, rsp_carry,
               rsp_sign, rsp_parity, rsp_overflow
    );
endinterface

// File: rtl/alu_stream_engine.sv
// alu_stream_engine: accepts ALU operations on a valid/ready request port,
// evaluates them in the accept cycle, and queues the results in a small
// in-order FIFO that is drained through a valid/ready response port.
// Ports:
//   clk       clock, all state updates on the rising edge
//   rst       asynchronous active-high reset
//   bus       alu_stream_if slave: request a/b/select in, result + flags out
//   ops_done  number of responses popped since reset (wraps)
module alu_stream_engine #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    alu_stream_if.slave      bus,
    output logic [CNT_W-1:0] ops_done
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = $clog2(DEPTH + 1);
    localparam logic [FCNT_W-1:0] FULL = FCNT_W'(DEPTH);

    // zero, sign and parity are derived from out at the FIFO head, so only
    // the flags that need the operands are stored.
    typedef struct packed {
        logic             ovf;
        logic             carry;
        logic [WIDTH-1:0] out;
    } result_t;

    function automatic result_t alu_eval(input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b,
                                         input logic [2:0]       sel);
        result_t          r;
        logic [WIDTH:0]   ext;
        r   = '0;
        ext = '0;
        case (sel)
            3'b000: begin
                ext     = {1'b0, a} + {1'b0, b};
                r.out   = ext[WIDTH-1:0];
                r.carry = ext[WIDTH];
                r.ovf   = (a[WIDTH-1] == b[WIDTH-1]) && (r.out[WIDTH-1] != a[WIDTH-1]);
            end
            3'b001: begin
                // Top bit of the widened difference is the unsigned borrow.
                ext     = {1'b0, a} - {1'b0, b};
                r.out   = ext[WIDTH-1:0];
                r.carry = ext[WIDTH];
                r.ovf   = (a[WIDTH-1] != b[WIDTH-1]) && (r.out[WIDTH-1] != a[WIDTH-1]);
            end
            3'b010: r.out = a & b;
            3'b011: r.out = a | b;
            3'b100: r.out = a ^ b;
            3'b101: r.out = ~a;
            3'b110: begin
                r.out   = {a[WIDTH-2:0], 1'b0};
                r.carry = a[WIDTH-1];
            end
            default: begin
                r.out   = {1'b0, a[WIDTH-1:1]};
                r.carry = a[0];
            end
        endcase
        return r;
    endfunction

    result_t             fifo_mem [DEPTH];
    result_t             new_res;
    result_t             head;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [FCNT_W-1:0]   count_q, count_d;
    logic [CNT_W-1:0]    ops_q, ops_d;
    logic                push;
    logic                pop;
    logic                valid;

    // req_ready depends only on registered occupancy (and reset), never on rsp_ready.
    assign bus.req_ready = !rst && (count_q < FULL);
    assign valid         = (count_q != '0);
    assign push          = bus.req_valid && bus.req_ready;
    assign pop           = valid && bus.rsp_ready;
    assign new_res       = alu_eval(bus.req_a, bus.req_b, bus.req_select);
    assign head          = fifo_mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ops_d    = ops_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            ops_d    = ops_q + CNT_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ops_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ops_q    <= ops_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= new_res;
        end
    end

    // Outputs come straight from the head entry, forced to zero when empty.
    assign bus.rsp_valid    = valid;
    assign bus.rsp_out      = valid ? head.out : '0;
    assign bus.rsp_zero     = valid && (head.out == '0);
    assign bus.rsp_carry    = valid && head.carry;
    assign bus.rsp_sign     = valid && head.out[WIDTH-1];
    assign bus.rsp_parity   = valid && (^head.out);
    assign bus.rsp_overflow = valid && head.ovf;
    assign ops_done         = ops_q;
endmodule

// File: tb/tb_alu_stream_engine.sv
module tb_alu_stream_engine;
    logic        clk;
    logic        rst;
    logic [15:0] ops_done;

    alu_stream_if #(.WIDTH(8)) bus ();

    alu_stream_engine #(.WIDTH(8), .DEPTH(4), .CNT_W(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .ops_done (ops_done)
    );

    initial begin
        clk = 1'b1;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0] out;
        logic       c;
        logic       v;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] s;
        logic [7:0] out;
        logic       c;
        logic       v;
        logic       z;
        logic       sg;
        logic       p;
    } vec_t;

    res_t mq[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_ops = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Reference computed with plain integer arithmetic on the opcode rules.
    function automatic res_t ref_op(input logic [7:0] a, input logic [7:0] b, input logic [2:0] s);
        int   ua, ub, sa, sb, r;
        res_t o;
        ua = int'(a);
        ub = int'(b);
        sa = (ua >= 128) ? ua - 256 : ua;
        sb = (ub >= 128) ? ub - 256 : ub;
        o.c = 1'b0;
        o.v = 1'b0;
        r = 0;
        case (s)
            3'd0: begin r = ua + ub; o.c = (r > 255); o.v = ((sa + sb) > 127) || ((sa + sb) < -128); end
            3'd1: begin r = ua - ub; o.c = (ua < ub); o.v = ((sa - sb) > 127) || ((sa - sb) < -128); end
            3'd2: r = ua & ub;
            3'd3: r = ua | ub;
            3'd4: r = ua ^ ub;
            3'd5: r = 255 - ua;
            3'd6: begin r = ua * 2; o.c = (ua >= 128); end
            default: begin r = ua / 2; o.c = ((ua % 2) == 1); end
        endcase
        o.out = 8'(r);
        return o;
    endfunction

    // One clock cycle, entered and left at a falling edge: drive, compare
    // against the model, then advance the model by the handshakes that the
    // next rising edge will perform.
    task automatic cycle(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] s, input logic rr);
        res_t h;
        bit   do_push, do_pop;
        bus.req_valid  = v;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_select = s;
        bus.rsp_ready  = rr;
        #1;
        chk("req_ready", 32'(bus.req_ready), 32'(mq.size() < 4));
        chk("rsp_valid", 32'(bus.rsp_valid), 32'(mq.size() != 0));
        chk("ops_done", 32'(ops_done), 32'(exp_ops % 65536));
        if (mq.size() != 0) begin
            h = mq[0];
            chk("rsp_out", 32'(bus.rsp_out), 32'(h.out));
            chk("rsp_carry", 32'(bus.rsp_carry), 32'(h.c));
            chk("rsp_overflow", 32'(bus.rsp_overflow), 32'(h.v));
            chk("rsp_zero", 32'(bus.rsp_zero), 32'(h.out == 8'd0));
            chk("rsp_sign", 32'(bus.rsp_sign), 32'(h.out >= 8'd128));
            chk("rsp_parity", 32'(bus.rsp_parity), 32'(($countones(h.out) % 2) == 1));
        end else begin
            chk("rsp_out_empty", 32'({bus.rsp_out, bus.rsp_zero, bus.rsp_carry, bus.rsp_sign,
                                      bus.rsp_parity, bus.rsp_overflow}), 32'd0);
        end
        do_push = v && (mq.size() < 4);
        do_pop  = rr && (mq.size() != 0);
        if (do_pop) begin
            void'(mq.pop_front());
            exp_ops++;
        end
        if (do_push) mq.push_back(ref_op(a, b, s));
        @(negedge clk);
    endtask

    vec_t vt[12];

    initial begin
        vt[0]  = '{8'h7F, 8'h01, 3'd0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        vt[1]  = '{8'h05, 8'h05, 3'd1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[2]  = '{8'h03, 8'h05, 3'd1, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
        vt[3]  = '{8'h81, 8'h00, 3'd6, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[4]  = '{8'h81, 8'h00, 3'd7, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vt[5]  = '{8'hFF, 8'h00, 3'd5, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[6]  = '{8'hFF, 8'h01, 3'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vt[7]  = '{8'h80, 8'h01, 3'd1, 8'h7F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[8]  = '{8'hF0, 8'h3C, 3'd2, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[9]  = '{8'hF0, 8'h0F, 3'd3, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[10] = '{8'hAA, 8'hFF, 3'd4, 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[11] = '{8'h80, 8'h80, 3'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        bus.req_valid  = 1'b0;
        bus.req_a      = 8'd0;
        bus.req_b      = 8'd0;
        bus.req_select = 3'd0;
        bus.rsp_ready  = 1'b0;
        rst            = 1'b1;

        // Reset state while rst is held
        #12;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_out", 32'(bus.rsp_out), 32'd0);
        chk("rst_ops_done", 32'(ops_done), 32'd0);
        #3;
        rst = 1'b0;

        // Table of single operations: push, check constants, pop
        for (int i = 0; i < 12; i++) begin
            cycle(1'b1, vt[i].a, vt[i].b, vt[i].s, 1'b0);
            bus.req_valid = 1'b0;
            #1;
            chk("tbl_valid", 32'(bus.rsp_valid), 32'd1);
            chk("tbl_out", 32'(bus.rsp_out), 32'(vt[i].out));
            chk("tbl_carry", 32'(bus.rsp_carry), 32'(vt[i].c));
            chk("tbl_ovf", 32'(bus.rsp_overflow), 32'(vt[i].v));
            chk("tbl_zero", 32'(bus.rsp_zero), 32'(vt[i].z));
            chk("tbl_sign", 32'(bus.rsp_sign), 32'(vt[i].sg));
            chk("tbl_parity", 32'(bus.rsp_parity), 32'(vt[i].p));
            cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
            #1;
            chk("tbl_ops_done", 32'(ops_done), 32'(i + 1));
        end

        // Back-pressure: five pushes with no drain, fifth must be refused
        for (int i = 0; i < 5; i++) cycle(1'b1, 8'(i * 16 + 3), 8'(i + 7), 3'(i), 1'b0);
        #1;
        chk("full_req_ready", 32'(bus.req_ready), 32'd0);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        #1;
        chk("after_pop_ready", 32'(bus.req_ready), 32'd1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        chk("drained", 32'(mq.size()), 32'd0);

        // Two entries queued, then six cycles of simultaneous push and pop
        cycle(1'b1, 8'h11, 8'h22, 3'd0, 1'b0);
        cycle(1'b1, 8'h33, 8'h44, 3'd1, 1'b0);
        begin
            int ops_before;
            ops_before = int'(ops_done);
            for (int i = 0; i < 6; i++) cycle(1'b1, 8'(8'h50 + i * 9), 8'(i * 5), 3'(i + 2), 1'b1);
            #1;
            chk("flow_valid", 32'(bus.rsp_valid), 32'd1);
            chk("flow_count", 32'(mq.size()), 32'd2);
            chk("flow_ops", 32'(ops_done), 32'(ops_before + 6));
        end
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 3'($urandom),
                  1'($urandom_range(0, 3) != 0));
        end
        while (mq.size() != 0) cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);

        // Mid-cycle asynchronous reset with three results queued
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(i + 1), 8'h10, 3'd0, 1'b0);
        chk("pre_rst_ops_nonzero", 32'(ops_done != 16'd0), 32'd1);
        #2;
        rst = 1'b1;
        bus.req_valid = 1'b1;
        #1;
        chk("arst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("arst_ops_done", 32'(ops_done), 32'd0);
        chk("arst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("arst_rsp_out", 32'(bus.rsp_out), 32'd0);
        mq.delete();
        exp_ops = 0;
        @(negedge clk);
        chk("arst_hold_valid", 32'(bus.rsp_valid), 32'd0);
        rst = 1'b0;
        cycle(1'b1, 8'h12, 8'h34, 3'd0, 1'b0);
        bus.req_valid = 1'b0;
        #1;
        chk("post_rst_out", 32'(bus.rsp_out), 32'h46);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b1);
        cycle(1'b0, 8'd0, 8'd0, 3'd0, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
